// File: rtl/inferred_adder4.sv
// Inferred-arithmetic carry-lookahead adder with group P/G terms and
// registered copies of sum, carry-out and signed overflow.
module inferred_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] Y,
  output logic             cout,
  output logic             ovf,
  output logic             gp,
  output logic             gg,
  output logic [WIDTH-1:0] y_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic             gg_int;
  logic [WIDTH-1:0] y_d;
  logic             cout_d;
  logic             ovf_d;

  assign p = A ^ B;
  assign g = A & B;

  // Each carry is a flat sum of products: g[j] masked by every propagate
  // above it, plus cin masked by all propagates below the carry.
  always_comb begin : carry_lookahead
    logic prod;
    logic acc;
    c      = '0;
    c[0]   = cin;
    gg_int = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      prod = 1'b1;
      acc  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (g[j] & prod);
        prod = prod & p[j];
      end
      if (i == WIDTH - 1) gg_int = acc;
      c[i+1] = acc | (prod & cin);
    end
  end

  assign Y    = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];
  assign gp   = &p;
  assign gg   = gg_int;

  always_comb begin
    y_d    = Y;
    cout_d = cout;
    ovf_d  = ovf;
    if (rst) begin
      y_d    = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    y_q    <= y_d;
    cout_q <= cout_d;
    ovf_q  <= ovf_d;
  end

endmodule

// File: tb/tb_inferred_adder4.sv
// Self-checking bench: combinational results checked directly against an
// arithmetic model; registered results go through a scoreboard queue.
module tb_inferred_adder4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = '0;
  logic [3:0] b   = '0;
  logic       cin = 1'b0;
  logic [3:0] y;
  logic       cout, ovf, gp, gg;
  logic [3:0] y_q;
  logic       cout_q, ovf_q;

  int tests  = 0;
  int fails  = 0;
  logic [5:0] sb_q[$];   // {y, cout, ovf} expected after the next edge

  inferred_adder4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .cin(cin),
    .Y(y), .cout(cout), .ovf(ovf), .gp(gp), .gg(gg),
    .y_q(y_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned and signed interpretations.
  function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic mc);
    int us, ss;
    logic [4:0] sum;
    us  = int'(ma) + int'(mb) + int'(mc);
    ss  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    sum = us[4:0];
    return {sum[3:0], sum[4], (ss > 7 || ss < -8)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (A=%0d B=%0d cin=%0d rst=%0d)",
               name, act, exp, a, b, cin, rst);
    end
  endtask

  // Apply one cycle of stimulus and queue the registered expectation.
  task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic dc,
                       input logic dr, output bit ok);
    logic [5:0] m;
    int ex_sum, f0;
    @(negedge clk);
    a = da; b = db; cin = dc; rst = dr;
    m = model(da, db, dc);
    sb_q.push_back(dr ? 6'd0 : m);
    #4;
    f0 = fails;
    ex_sum = int'(da) + int'(db) + int'(dc);
    check("sum", int'({cout, y}), ex_sum);
    check("ovf", int'(ovf), int'(m[0]));
    check("gp", int'(gp), int'((da ^ db) == 4'hF));
    check("gg", int'(gg), int'((int'(da) + int'(db)) > 15));
    check("cout_eq", int'(cout), int'(gg | (gp & dc)));
    ok = (fails == f0);
  endtask

  // Monitor: registered outputs are compared one cycle after stimulus.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("y_q", int'(y_q), int'(e[5:2]));
        check("cout_q", int'(cout_q), int'(e[1]));
        check("ovf_q", int'(ovf_q), int'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit stop;
    logic [3:0] ta, tb_;
    logic tc;

    // Reset held for two edges; combinational path must still work.
    drive(4'h5, 4'h6, 1'b1, 1'b1, ok);
    drive(4'hF, 4'hF, 1'b1, 1'b1, ok);
    // Release: 3+4+1 -> y_q=8 next edge.
    drive(4'h3, 4'h4, 1'b1, 1'b0, ok);

    // Directed corners with explicit expected values.
    drive(4'hF, 4'hF, 1'b1, 1'b0, ok);
    check("ff1_y", int'(y), 15); check("ff1_cout", int'(cout), 1);
    check("ff1_gp", int'(gp), 0); check("ff1_gg", int'(gg), 1);
    drive(4'h7, 4'h1, 1'b0, 1'b0, ok);
    check("71_y", int'(y), 8); check("71_cout", int'(cout), 0);
    check("71_ovf", int'(ovf), 1);
    drive(4'h8, 4'h8, 1'b0, 1'b0, ok);
    check("88_y", int'(y), 0); check("88_cout", int'(cout), 1);
    check("88_ovf", int'(ovf), 1);
    drive(4'hA, 4'h5, 1'b1, 1'b0, ok);
    check("a5_y", int'(y), 0); check("a5_cout", int'(cout), 1);
    check("a5_gp", int'(gp), 1); check("a5_gg", int'(gg), 0);
    drive(4'hF, 4'h0, 1'b1, 1'b0, ok);
    check("f01_y", int'(y), 0); check("f01_cout", int'(cout), 1);

    // Exhaustive sweep, stopping at the first combinational mismatch.
    stop = 1'b0;
    for (int i = 0; i < 512 && !stop; i++) begin
      ta = i[3:0]; tb_ = i[7:4]; tc = i[8];
      drive(ta, tb_, tc, 1'b0, ok);
      if (!ok) stop = 1'b1;
    end

    // Reset asserted mid-stream, then resumed.
    drive(4'h9, 4'h3, 1'b0, 1'b0, ok);
    drive(4'hC, 4'h2, 1'b1, 1'b1, ok);
    drive(4'h6, 4'h6, 1'b0, 1'b0, ok);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ok);
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
